// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART blocks (receiver, baud clock generator,
//   future transmitter).
//
//   Contents:
//     UART_SAMPLING_DELAY_W   width of the sampling-delay (clocks per bit) bus
//     UART_MIN_SAMPLING_DELAY smallest usable bit period in system clocks
//     UART_DEFAULT_DATA_BITS  default data bits per frame
//     rx_state_e              receiver FSM state encoding
//     clamp_sampling_delay()  raises a requested bit period to the minimum
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_SAMPLING_DELAY_W   = 32;
  localparam int UART_MIN_SAMPLING_DELAY = 2;
  localparam int UART_DEFAULT_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  // A bit period below two clocks leaves no room for a half-bit offset, so
  // smaller requests are raised to the minimum.
  function automatic logic [UART_SAMPLING_DELAY_W-1:0] clamp_sampling_delay(
    input logic [UART_SAMPLING_DELAY_W-1:0] n
  );
    logic [UART_SAMPLING_DELAY_W-1:0] min_n;
    min_n = UART_SAMPLING_DELAY_W'(UART_MIN_SAMPLING_DELAY);
    return (n < min_n) ? min_n : n;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
//   Signal bundle between the RX pad / host register side and uart_rx.
//
//   Signals:
//     I_sampling_delay  system clocks per bit period (N), unsigned
//     I_rx              serial input, idle high, asynchronous
//     O_data            last correctly framed word
//     O_valid           one-cycle pulse: O_data updated
//     O_frame_err       one-cycle pulse: stop bit sampled low
//     O_busy            high while the receiver is not idle
//     dbg_state         receiver FSM state, for observation only
//
//   Handshake: O_valid and O_frame_err are single-cycle strobes with no
//   ready/back-pressure; the consumer must capture O_data in the cycle
//   O_valid is high. O_data holds its value until the next good frame.
//
//   Modports:
//     master  drives the line and bit period, observes results (host / bench)
//     slave   the receiver itself
// ---------------------------------------------------------------------------
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DEFAULT_DATA_BITS
) ();

  logic [UART_SAMPLING_DELAY_W-1:0] I_sampling_delay;
  logic                             I_rx;
  logic [DATA_BITS-1:0]             O_data;
  logic                             O_valid;
  logic                             O_frame_err;
  logic                             O_busy;
  rx_state_e                        dbg_state;

  modport master (
    output I_sampling_delay,
    output I_rx,
    input  O_data,
    input  O_valid,
    input  O_frame_err,
    input  O_busy,
    input  dbg_state
  );

  modport slave (
    input  I_sampling_delay,
    input  I_rx,
    output O_data,
    output O_valid,
    output O_frame_err,
    output O_busy,
    output dbg_state
  );

endinterface

// File: rtl/uart_sync.sv
// ---------------------------------------------------------------------------
// uart_sync
//   Multi-flop synchroniser for an asynchronous pad input (RX, CTS, ...).
//   Flops reset to 1 so an idle-high UART line never shows a false start
//   edge while coming out of reset.
//
//   Ports:
//     I_clk    system clock, rising edge
//     I_reset  asynchronous, active-high reset (all stages load 1)
//     I_async  asynchronous input
//     O_sync   synchronised output, STAGES clocks behind I_async
// ---------------------------------------------------------------------------
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic I_clk,
  input  logic I_reset,
  input  logic I_async,
  output logic O_sync
);

  logic [STAGES-1:0] sync_ff;

  // Shift toward the MSB; the MSB is the most-settled stage.
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      sync_ff <= '1;
    end else begin
      sync_ff <= STAGES'({sync_ff, I_async});
    end
  end

  assign O_sync = sync_ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   8N1-style UART receiver running directly on the system clock. Detects
//   the start bit, samples each bit at its middle and delivers the word
//   LSB first.
//
//   Ports:
//     I_clk    system clock, rising edge
//     I_reset  asynchronous, active-high reset
//     bus      uart_rx_if.slave: I_sampling_delay, I_rx in;
//              O_data, O_valid, O_frame_err, O_busy, dbg_state out
//
//   Timing, relative to the synchronised line rx_s, with t0 the edge on
//   which IDLE sees rx_s low, Nl the latched (clamped) bit period and
//   H = Nl/2:
//     start bit checked at t0+H
//     data bit i sampled at t0+H+(i+1)*Nl
//     stop bit sampled at t0+H+(DATA_BITS+1)*Nl
//   The receiver is back in IDLE half a bit before the stop bit ends, so a
//   start bit directly following the stop bit is caught.
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = UART_DEFAULT_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic     I_clk,
  input  logic     I_reset,
  uart_rx_if.slave bus
);

  localparam int SD_W  = UART_SAMPLING_DELAY_W;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  // -------------------------------------------------------------------------
  // Line synchroniser
  // -------------------------------------------------------------------------
  logic rx_s;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .I_clk   (I_clk),
    .I_reset (I_reset),
    .I_async (bus.I_rx),
    .O_sync  (rx_s)
  );

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  rx_state_e            state_q,   state_d;
  logic [SD_W-1:0]      cnt_q,     cnt_d;
  logic [SD_W-1:0]      nl_q,      nl_d;     // latched bit period
  logic [SD_W-1:0]      h_q,       h_d;      // latched half bit period
  logic [IDX_W-1:0]     idx_q,     idx_d;    // data bit being received
  logic [DATA_BITS-1:0] shreg_q,   shreg_d;
  logic [DATA_BITS-1:0] data_q,    data_d;
  logic                 valid_q,   valid_d;
  logic                 ferr_q,    ferr_d;

  logic [SD_W-1:0]      nl_req;              // clamped request, used at start

  assign nl_req = clamp_sampling_delay(bus.I_sampling_delay);

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nl_d    = nl_q;
    h_d     = h_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          // Bit period is frozen here so mid-frame changes of the
          // requested delay only affect the next frame.
          state_d = START;
          nl_d    = nl_req;
          h_d     = nl_req >> 1;
        end
      end

      START: begin
        if (cnt_q == h_q - SD_W'(1)) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            // Line went back high before mid start bit: a glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + SD_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == nl_q - SD_W'(1)) begin
          cnt_d   = '0;
          // LSB arrives first, so new bits enter at the top and move down.
          shreg_d = DATA_BITS'({rx_s, shreg_q} >> 1);
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + SD_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == nl_q - SD_W'(1)) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + SD_W'(1);
        end
      end

      BREAK: begin
        // Hold off until the line is released so a stuck-low line does not
        // look like an endless stream of start bits.
        cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      cnt_q   <= '0;
      nl_q    <= SD_W'(UART_MIN_SAMPLING_DELAY);
      h_q     <= SD_W'(UART_MIN_SAMPLING_DELAY / 2);
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      nl_q    <= nl_d;
      h_q     <= h_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.O_data      = data_q;
  assign bus.O_valid     = valid_q;
  assign bus.O_frame_err = ferr_q;
  assign bus.O_busy      = (state_q != IDLE);
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Self-checking bench for uart_rx: directed corner sequences, a table of
//   frames with hand-written expected results, and random frames checked
//   against a frame-level model (good stop bit -> word delivered, bad stop
//   bit -> error strobe with the previous word kept).
// ---------------------------------------------------------------------------
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DB = 8;
  localparam int SS = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic I_clk   = 1'b0;
  logic I_reset = 1'b1;
  int   cyc     = 0;

  always #5 I_clk = ~I_clk;
  always @(posedge I_clk) cyc <= cyc + 1;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(
    .DATA_BITS   (DB),
    .SYNC_STAGES (SS)
  ) dut (
    .I_clk   (I_clk),
    .I_reset (I_reset),
    .bus     (bus)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int            errors = 0;
  int            checks = 0;
  logic [DB:0]   exp_q[$];        // {is_frame_err, data}
  int            valid_cyc[$];
  int            n_valid = 0;
  int            n_ferr  = 0;
  int            fall_cyc = 0;
  logic [DB-1:0] model_last = '0; // word the receiver should be holding
  logic [DB:0]   mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model.
  task automatic model_expect(input logic [DB-1:0] d, input logic stop_bit);
    if (stop_bit) begin
      exp_q.push_back({1'b0, d});
      model_last = d;
    end else begin
      exp_q.push_back({1'b1, model_last});
    end
  endtask

  // Pulse monitor, sampled on the falling edge.
  always @(negedge I_clk) begin
    if (!I_reset && (bus.O_valid || bus.O_frame_err)) begin
      chk("valid_ferr_exclusive", 32'(bus.O_valid & bus.O_frame_err), 32'd0);
      if (bus.O_valid) begin
        n_valid++;
        valid_cyc.push_back(cyc);
      end
      if (bus.O_frame_err) n_ferr++;
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_kind", 32'(bus.O_frame_err), 32'(mon_e[DB]));
        chk("pulse_data", 32'(bus.O_data), 32'(mon_e[DB-1:0]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (entered and left #1 after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic drive_frame(input logic [DB-1:0] d, input int n, input logic stop_bit);
    fall_cyc = cyc;
    bus.I_rx = 1'b0;
    repeat (n) @(posedge I_clk);
    #1;
    for (int i = 0; i < DB; i++) begin
      bus.I_rx = d[i];
      repeat (n) @(posedge I_clk);
      #1;
    end
    bus.I_rx = stop_bit;
    repeat (n) @(posedge I_clk);
    #1;
  endtask

  task automatic wait_idle(input int limit);
    int c = 0;
    while (bus.O_busy !== 1'b0 && c < limit) begin
      @(posedge I_clk);
      #1;
      c++;
    end
    chk("idle_timeout", 32'(c < limit), 32'd1);
    repeat (3) @(posedge I_clk);
    #1;
  endtask

  // Full frame with model update; a bad stop bit is held low for hold
  // extra cycles before the line is released.
  task automatic send(input logic [DB-1:0] d, input int n, input logic stop_bit, input int hold);
    bus.I_sampling_delay = 32'(n);
    model_expect(d, stop_bit);
    drive_frame(d, n, stop_bit);
    if (!stop_bit) begin
      repeat (hold) @(posedge I_clk);
      #1;
      bus.I_rx = 1'b1;
    end
    wait_idle(400);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] data;
    int         n;
    logic       stop_bit;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int v0, f0, busy_cnt, n, gap;
    logic [7:0] d;
    logic stop_bit;

    tbl[0] = '{8'h01, 4, 1'b1, 1'b0, 8'h01};
    tbl[1] = '{8'h80, 5, 1'b1, 1'b0, 8'h80};
    tbl[2] = '{8'hF0, 3, 1'b0, 1'b1, 8'h80};
    tbl[3] = '{8'h0F, 6, 1'b1, 1'b0, 8'h0F};
    tbl[4] = '{8'h55, 2, 1'b1, 1'b0, 8'h55};
    tbl[5] = '{8'hAA, 7, 1'b0, 1'b1, 8'h55};

    bus.I_rx             = 1'b1;
    bus.I_sampling_delay = 32'd16;

    // Reset state
    repeat (3) @(posedge I_clk);
    #1;
    chk("reset_busy",  32'(bus.O_busy), 32'd0);
    chk("reset_data",  32'(bus.O_data), 32'd0);
    chk("reset_valid", 32'(bus.O_valid), 32'd0);
    chk("reset_ferr",  32'(bus.O_frame_err), 32'd0);
    chk("reset_state", 32'(bus.dbg_state), 32'(IDLE));
    I_reset = 1'b0;
    repeat (4) @(posedge I_clk);
    #1;
    chk("idle_after_release", 32'(bus.O_busy), 32'd0);

    // Nominal 0xA5 at N=16 with latency check
    valid_cyc.delete();
    f0 = n_ferr;
    send(8'hA5, 16, 1'b1, 0);
    chk("nominal_pulses", 32'(valid_cyc.size()), 32'd1);
    if (valid_cyc.size() == 1)
      chk("nominal_latency", 32'(valid_cyc[0] - fall_cyc), 32'(SS + 8 + 144 + 1));
    chk("nominal_data", 32'(bus.O_data), 32'h A5);
    chk("nominal_no_ferr", 32'(n_ferr - f0), 32'd0);

    // Framing error: 0x3C with low stop bit, held low 40 more cycles
    bus.I_sampling_delay = 32'd16;
    f0 = n_ferr;
    v0 = n_valid;
    model_expect(8'h3C, 1'b0);
    drive_frame(8'h3C, 16, 1'b0);
    repeat (40) @(posedge I_clk);
    #1;
    chk("ferr_busy_held", 32'(bus.O_busy), 32'd1);
    chk("ferr_state_break", 32'(bus.dbg_state), 32'(BREAK));
    chk("ferr_one_pulse", 32'(n_ferr - f0), 32'd1);
    chk("ferr_no_valid", 32'(n_valid - v0), 32'd0);
    chk("ferr_data_kept", 32'(bus.O_data), 32'h A5);
    bus.I_rx = 1'b1;
    wait_idle(50);
    send(8'h5A, 16, 1'b1, 0);
    chk("after_ferr_data", 32'(bus.O_data), 32'h5A);

    // Glitch rejection: 3-cycle low pulse
    v0 = n_valid;
    f0 = n_ferr;
    busy_cnt = 0;
    bus.I_rx = 1'b0;
    repeat (3) @(posedge I_clk);
    #1;
    bus.I_rx = 1'b1;
    repeat (30) begin
      @(negedge I_clk);
      if (bus.O_busy) busy_cnt++;
    end
    chk("glitch_busy_cycles", 32'(busy_cnt), 32'd8);
    chk("glitch_no_valid", 32'(n_valid - v0), 32'd0);
    chk("glitch_no_ferr", 32'(n_ferr - f0), 32'd0);
    chk("glitch_idle", 32'(bus.O_busy), 32'd0);
    @(posedge I_clk);
    #1;

    // Back-to-back at N=10: 0x00 then 0xFF, no idle gap
    bus.I_sampling_delay = 32'd10;
    valid_cyc.delete();
    model_expect(8'h00, 1'b1);
    model_expect(8'hFF, 1'b1);
    drive_frame(8'h00, 10, 1'b1);
    drive_frame(8'hFF, 10, 1'b1);
    wait_idle(200);
    chk("b2b_pulses", 32'(valid_cyc.size()), 32'd2);
    if (valid_cyc.size() == 2)
      chk("b2b_spacing", 32'(valid_cyc[1] - valid_cyc[0]), 32'd100);
    chk("b2b_last_data", 32'(bus.O_data), 32'hFF);

    // Clamp: requested delay 1 behaves as 2
    bus.I_sampling_delay = 32'd1;
    model_expect(8'h81, 1'b1);
    drive_frame(8'h81, 2, 1'b1);
    wait_idle(100);
    chk("clamp_data", 32'(bus.O_data), 32'h81);

    // Latch: delay changed to 8 mid-frame; frame still runs at 16
    bus.I_sampling_delay = 32'd16;
    model_expect(8'hC3, 1'b1);
    fork
      drive_frame(8'hC3, 16, 1'b1);
      begin
        repeat (60) @(posedge I_clk);
        #1;
        bus.I_sampling_delay = 32'd8;
      end
    join
    wait_idle(100);
    chk("latch_data", 32'(bus.O_data), 32'hC3);
    model_expect(8'h96, 1'b1);
    drive_frame(8'h96, 8, 1'b1);
    wait_idle(100);
    chk("latch_next_data", 32'(bus.O_data), 32'h96);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      bus.I_sampling_delay = 32'(tbl[i].n);
      exp_q.push_back({tbl[i].exp_err, tbl[i].exp_data});
      if (!tbl[i].exp_err) model_last = tbl[i].exp_data;
      f0 = n_ferr;
      drive_frame(tbl[i].data, tbl[i].n, tbl[i].stop_bit);
      if (!tbl[i].stop_bit) begin
        repeat (2 * tbl[i].n) @(posedge I_clk);
        #1;
        bus.I_rx = 1'b1;
      end
      wait_idle(400);
      chk("tbl_data", 32'(bus.O_data), 32'(tbl[i].exp_data));
      chk("tbl_ferr_count", 32'(n_ferr - f0), 32'(tbl[i].exp_err));
    end

    // Random frames against the model
    for (int i = 0; i < 12; i++) begin
      d        = 8'($urandom_range(0, 255));
      n        = int'($urandom_range(2, 20));
      stop_bit = ($urandom_range(0, 4) != 0);
      gap      = int'($urandom_range(0, 5));
      send(d, n, stop_bit, n);
      chk("rand_data", 32'(bus.O_data), 32'(model_last));
      repeat (gap) @(posedge I_clk);
      #1;
    end

    // Asynchronous reset during data bit 3 of 0x5A
    bus.I_sampling_delay = 32'd16;
    d = 8'h5A;
    bus.I_rx = 1'b0;
    repeat (16) @(posedge I_clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      bus.I_rx = d[i];
      repeat (16) @(posedge I_clk);
      #1;
    end
    bus.I_rx = d[3];
    repeat (8) @(posedge I_clk);
    #1;
    chk("midframe_busy", 32'(bus.O_busy), 32'd1);
    chk("midframe_state", 32'(bus.dbg_state), 32'(DATA));
    #2;
    I_reset = 1'b1;
    #1;
    chk("async_rst_busy",  32'(bus.O_busy), 32'd0);
    chk("async_rst_data",  32'(bus.O_data), 32'd0);
    chk("async_rst_valid", 32'(bus.O_valid), 32'd0);
    chk("async_rst_ferr",  32'(bus.O_frame_err), 32'd0);
    chk("async_rst_state", 32'(bus.dbg_state), 32'(IDLE));
    model_last = '0;
    bus.I_rx = 1'b1;
    @(posedge I_clk);
    #1;
    I_reset = 1'b0;
    repeat (4) @(posedge I_clk);
    #1;
    send(8'h5A, 16, 1'b1, 0);
    chk("post_reset_data", 32'(bus.O_data), 32'h5A);

    // Every expected pulse must have been seen
    repeat (5) @(posedge I_clk);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
